// File: rtl/keypad_scan_if.sv
// Keypad-side and consumer-side signals of the 4x4 scanner; the scanner is master.
// Combinational bundle only, no latency; no backpressure, key_valid is a strobe.
interface keypad_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_valid;
  logic        multi;

  modport master (
    input  row,
    output col,
    output onehot,
    output key_valid,
    output multi
  );

  modport slave (
    output row,
    input  col,
    input  onehot,
    input  key_valid,
    input  multi
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner and sweep debouncer; onehot updates 2 cycles after the accepting sweep ends.
// No backpressure: key_valid is a single-cycle strobe the consumer must take when it appears.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE - 1);
  localparam logic [SW-1:0] STABLE_ACC = SW'((DEBOUNCE >= 2) ? DEBOUNCE - 2 : 0);

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_t;

  col_state_t      state;
  col_state_t      state_nxt;
  logic [3:0]      col;
  logic [DW-1:0]   div_cnt;
  logic            sample;
  logic            sweep_end;
  logic [15:0]     sweep_map;
  logic [15:0]     prev_map;
  logic [15:0]     new_map;
  logic [15:0]     acc_map;
  logic [SW-1:0]   stable_cnt;
  logic            same;
  logic            acc;
  logic            acc_zero;
  logic            acc_single;
  logic [15:0]     onehot;
  logic            key_valid;
  logic            multi;

  assign sample     = (div_cnt == DIV_LAST);
  assign sweep_end  = sample && (state == COL3);
  assign same       = (new_map == prev_map);
  assign acc_zero   = (acc_map == 16'd0);
  assign acc_single = !acc_zero && ((acc_map & (acc_map - 16'd1)) == 16'd0);

  assign kp.col       = col;
  assign kp.onehot    = onehot;
  assign kp.key_valid = key_valid;
  assign kp.multi     = multi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COL0;
    end else begin
      state <= state_nxt;
    end
  end

  // col is decoded from the state register so it is always exactly one-low, even out of reset
  always_comb begin
    state_nxt = state;
    col       = 4'b1110;
    case (state)
      COL0: begin
        col = 4'b1110;
        if (sample) state_nxt = COL1;
      end
      COL1: begin
        col = 4'b1101;
        if (sample) state_nxt = COL2;
      end
      COL2: begin
        col = 4'b1011;
        if (sample) state_nxt = COL3;
      end
      COL3: begin
        col = 4'b0111;
        if (sample) state_nxt = COL0;
      end
    endcase
  end

  // The final column is merged combinationally so the sweep can be judged on its own sample cycle
  always_comb begin
    new_map = sweep_map;
    for (int r = 0; r < 4; r++) begin
      new_map[4*r+3] = ~kp.row[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      sweep_map  <= '0;
      prev_map   <= '0;
      acc_map    <= '0;
      stable_cnt <= '0;
      acc        <= 1'b0;
      onehot     <= '0;
      key_valid  <= 1'b0;
      multi      <= 1'b0;
    end else begin
      div_cnt   <= sample ? '0 : div_cnt + 1'b1;
      acc       <= 1'b0;
      key_valid <= 1'b0;

      if (sample) begin
        for (int c = 0; c < 4; c++) begin
          if (state == col_state_t'(c)) begin
            for (int r = 0; r < 4; r++) begin
              sweep_map[4*r+c] <= ~kp.row[r];
            end
          end
        end
      end

      if (sweep_end) begin
        if (same) begin
          if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 1'b1;
        end else begin
          stable_cnt <= '0;
        end
        prev_map <= new_map;
        if (same && (DEBOUNCE == 1 || stable_cnt == STABLE_ACC)) begin
          acc     <= 1'b1;
          acc_map <= new_map;
        end
      end

      // Multi-key maps keep the last single key on onehot so the digit encoder never sees two bits
      if (acc) begin
        if (acc_zero) begin
          onehot <= '0;
          multi  <= 1'b0;
        end else if (acc_single) begin
          onehot    <= acc_map;
          multi     <= 1'b0;
          key_valid <= (acc_map != onehot);
        end else begin
          multi <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives row from the pressed-key set and col,
// and a sweep-level reference model predicts col, onehot, key_valid and multi every cycle.
module tb_keypad_scan;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int SWEEP = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = 16'd0;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          cyc;
  logic [15:0] last_map;
  int          run_len;
  logic [15:0] m_onehot;
  logic        m_kv;
  logic        m_multi;
  int          pend_at;
  logic [15:0] pend_map;

  // observation tallies
  int col_bad;
  int out_bad;
  int first_bad;
  int kv_seen;
  int m_kv_seen;

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.master)
  );

  always #5 clk = ~clk;

  // pressed key pulls its row low while its column is driven low
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !kp.col[c]) kp.row[r] = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic model_reset();
    cyc      = 0;
    last_map = 16'd0;
    run_len  = 1;
    m_onehot = 16'd0;
    m_kv     = 1'b0;
    m_multi  = 1'b0;
    pend_at  = -1;
    pend_map = 16'd0;
  endtask

  task automatic clear_stats();
    col_bad   = 0;
    out_bad   = 0;
    first_bad = -1;
    kv_seen   = 0;
    m_kv_seen = 0;
  endtask

  // Advance n cycles, updating the model and tallying disagreements with it
  task automatic cycles(int n);
    logic [3:0] exp_col;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (cyc % SWEEP == SWEEP - 1) begin
        if (keys == last_map) run_len++;
        else run_len = 1;
        last_map = keys;
        if (DB == 1 || run_len == DB) begin
          pend_map = keys;
          pend_at  = cyc + 2;
        end
      end
      cyc++;
      m_kv = 1'b0;
      if (cyc == pend_at) begin
        case ($countones(pend_map))
          0: begin
            m_onehot = 16'd0;
            m_multi  = 1'b0;
          end
          1: begin
            m_kv     = (pend_map != m_onehot);
            m_onehot = pend_map;
            m_multi  = 1'b0;
          end
          default: m_multi = 1'b1;
        endcase
      end
      #1;
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
      if (kp.col !== exp_col) col_bad++;
      if (kp.onehot !== m_onehot || kp.key_valid !== m_kv || kp.multi !== m_multi) begin
        if (out_bad == 0) first_bad = cyc;
        out_bad++;
      end
      if (kp.key_valid === 1'b1) kv_seen++;
      if (m_kv) m_kv_seen++;
    end
  endtask

  task automatic sweeps(logic [15:0] k, int n);
    keys = k;
    cycles(n * SWEEP);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    keys = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (kp.col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b, required 1110", kp.col); end
    tests++; if (kp.onehot !== 16'd0) begin fails++; $display("FAIL reset_onehot: got %h, required 0000", kp.onehot); end
    tests++; if (kp.key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b, required 0", kp.key_valid); end
    tests++; if (kp.multi !== 1'b0) begin fails++; $display("FAIL reset_multi: got %b, required 0", kp.multi); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    clear_stats();
    sweeps(16'd0, 3);
    tests++; if (col_bad !== 0) begin fails++; $display("FAIL idle_col: %0d cycles with wrong col, required 0", col_bad); end
    tests++; if (out_bad !== 0) begin fails++; $display("FAIL idle_outputs: %0d cycles off model (first %0d), required 0", out_bad, first_bad); end
    tests++; if (kv_seen !== 0) begin fails++; $display("FAIL idle_key_valid: %0d pulses, required 0", kv_seen); end
    tests++; if (kp.onehot !== 16'd0) begin fails++; $display("FAIL idle_onehot: got %h, required 0000", kp.onehot); end
  endtask

  task automatic test_single_press();
    clear_stats();
    sweeps(16'h0080, 2);
    tests++; if (kp.onehot !== 16'd0) begin fails++; $display("FAIL press_early: got %h one cycle after 2nd sweep, required 0000", kp.onehot); end
    cycles(1);
    tests++; if (kp.onehot !== 16'h0080) begin fails++; $display("FAIL press_onehot: got %h, required 0080", kp.onehot); end
    tests++; if (kp.key_valid !== 1'b1) begin fails++; $display("FAIL press_key_valid: got %b, required 1", kp.key_valid); end
    cycles(SWEEP - 1);
    sweeps(16'h0080, 5);
    tests++; if (kv_seen !== 1) begin fails++; $display("FAIL press_held_pulses: %0d pulses, required 1", kv_seen); end
    tests++; if (out_bad !== 0 || col_bad !== 0) begin fails++; $display("FAIL press_model: %0d output / %0d col bad cycles, required 0/0", out_bad, col_bad); end
  endtask

  task automatic test_bounce();
    sweeps(16'd0, 2);
    clear_stats();
    for (int i = 0; i < 6; i++) sweeps((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
    tests++; if (kp.onehot !== 16'd0 || kv_seen !== 0) begin fails++; $display("FAIL bounce_hold: onehot %h pulses %0d, required 0000 and 0", kp.onehot, kv_seen); end
    sweeps(16'h0008, 1);
    tests++; if (kp.onehot !== 16'd0) begin fails++; $display("FAIL bounce_first_solid: got %h, required 0000", kp.onehot); end
    sweeps(16'h0008, 1);
    cycles(1);
    tests++; if (kp.onehot !== 16'h0008 || kp.key_valid !== 1'b1) begin fails++; $display("FAIL bounce_accept: onehot %h kv %b, required 0008 and 1", kp.onehot, kp.key_valid); end
    cycles(SWEEP - 1);
    tests++; if (out_bad !== 0) begin fails++; $display("FAIL bounce_model: %0d bad cycles (first %0d), required 0", out_bad, first_bad); end
  endtask

  task automatic test_two_keys();
    sweeps(16'h0040, 3);
    tests++; if (kp.onehot !== 16'h0040) begin fails++; $display("FAIL two_first: got %h, required 0040", kp.onehot); end
    clear_stats();
    sweeps(16'h0048, 3);
    tests++; if (kp.multi !== 1'b1 || kp.onehot !== 16'h0040) begin fails++; $display("FAIL two_multi: multi %b onehot %h, required 1 and 0040", kp.multi, kp.onehot); end
    sweeps(16'h0040, 3);
    tests++; if (kp.multi !== 1'b0 || kp.onehot !== 16'h0040) begin fails++; $display("FAIL two_release: multi %b onehot %h, required 0 and 0040", kp.multi, kp.onehot); end
    tests++; if (kv_seen !== 0 || out_bad !== 0) begin fails++; $display("FAIL two_pulses: %0d pulses, %0d bad cycles, required 0 and 0", kv_seen, out_bad); end
  endtask

  task automatic test_release_repress();
    clear_stats();
    sweeps(16'h2000, 3);
    tests++; if (kp.onehot !== 16'h2000) begin fails++; $display("FAIL repress_first: got %h, required 2000", kp.onehot); end
    sweeps(16'h0000, 3);
    tests++; if (kp.onehot !== 16'h0000) begin fails++; $display("FAIL repress_released: got %h, required 0000", kp.onehot); end
    sweeps(16'h2000, 3);
    tests++; if (kp.onehot !== 16'h2000) begin fails++; $display("FAIL repress_second: got %h, required 2000", kp.onehot); end
    tests++; if (kv_seen !== 2 || out_bad !== 0) begin fails++; $display("FAIL repress_pulses: %0d pulses, %0d bad cycles, required 2 and 0", kv_seen, out_bad); end
  endtask

  task automatic test_reset_mid_sweep();
    clear_stats();
    sweeps(16'h0100, 1);
    cycles(2 * SD + 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (kp.col !== 4'b1110 || kp.onehot !== 16'd0) begin fails++; $display("FAIL midrst_outputs: col %b onehot %h, required 1110 and 0000", kp.col, kp.onehot); end
    rst = 1'b0;
    model_reset();
    clear_stats();
    sweeps(16'h0100, 1);
    tests++; if (kp.onehot !== 16'd0) begin fails++; $display("FAIL midrst_history: got %h after one fresh sweep, required 0000", kp.onehot); end
    sweeps(16'h0100, 1);
    cycles(1);
    tests++; if (kp.onehot !== 16'h0100 || kp.key_valid !== 1'b1) begin fails++; $display("FAIL midrst_accept: onehot %h kv %b, required 0100 and 1", kp.onehot, kp.key_valid); end
    cycles(SWEEP - 1);
    tests++; if (out_bad !== 0 || col_bad !== 0) begin fails++; $display("FAIL midrst_model: %0d output / %0d col bad cycles, required 0/0", out_bad, col_bad); end
  endtask

  task automatic test_random();
    logic [15:0] k;
    k = 16'd0;
    clear_stats();
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: k = k;
        3:       k = 16'(1) << $urandom_range(0, 15);
        default: k = ($urandom_range(0, 1) == 0) ? 16'd0
                     : ((16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15)));
      endcase
      sweeps(k, 1);
    end
    sweeps(k, 2);
    tests++; if (col_bad !== 0) begin fails++; $display("FAIL random_col: %0d bad cycles, required 0", col_bad); end
    tests++; if (out_bad !== 0) begin fails++; $display("FAIL random_outputs: %0d cycles off model (first %0d), required 0", out_bad, first_bad); end
    tests++; if (kv_seen !== m_kv_seen) begin fails++; $display("FAIL random_pulses: %0d pulses, required %0d", kv_seen, m_kv_seen); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_press();
    test_bounce();
    test_two_keys();
    test_release_repress();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
